// File: rtl/mdu_unit.sv
// HI/LO multiply/divide unit: results computed at launch, held in a pending register and
// committed after MULT_CYCLES/DIV_CYCLES; MADD/MADDU are present only when MDU_MADD_EN is defined.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Shared multiplier: sign-extend to 64 bits so one modular product serves both signednesses.
  logic        mul_sgn;
  logic [63:0] mul_a, mul_b, prod;

  always_comb begin
    mul_sgn = (op == OP_MULT) || (op == OP_MADD);
    mul_a   = {{32{mul_sgn & rs_data[31]}}, rs_data};
    mul_b   = {{32{mul_sgn & rt_data[31]}}, rt_data};
    prod    = mul_a * mul_b;
  end

  // Signed division via magnitudes; this also yields 0x80000000/-1 = 0x80000000 rem 0.
  logic        div_sgn, a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, uq, ur, quo, rem;

  always_comb begin
    div_sgn  = (op == OP_DIV);
    a_neg    = div_sgn & rs_data[31];
    b_neg    = div_sgn & rt_data[31];
    a_mag    = a_neg ? (32'd0 - rs_data) : rs_data;
    b_mag    = b_neg ? (32'd0 - rt_data) : rt_data;
    div_zero = (rt_data == 32'd0);
    uq       = 32'd0;
    ur       = 32'd0;
    if (!div_zero) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    quo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem = a_neg ? (32'd0 - ur) : ur;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {phi_d, plo_d} = prod;
              cnt_d          = 4'(MULT_CYCLES);
              state_d        = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero still takes the full latency but commits the current HI/LO.
              if (div_zero) begin
                phi_d = hi_q;
                plo_d = lo_q;
              end else begin
                phi_d = rem;
                plo_d = quo;
              end
              cnt_d   = 4'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              {phi_d, plo_d} = {hi_q, lo_q} + prod;
              cnt_d          = 4'(MULT_CYCLES);
              state_d        = S_RUN;
            end
`else
            OP_MADD, OP_MADDU: begin
            end
`endif
            default: begin
            end
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus queues expected HI/LO commits, a monitor checks each one.
module tb_mdu_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.h = h;
    e.l = l;
    exp_q.push_back(e);
  endtask

  // Drive a one-cycle start; returns 1 time unit after the launch edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count busy cycles after a launch, checking HI/LO hold their old values meanwhile.
  task automatic run_busy(input string name, input int exp_n);
    int          n;
    logic        stable;
    logic [31:0] h0, l0;
    n      = 0;
    stable = 1'b1;
    h0     = hi;
    l0     = lo;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        if (hi !== h0 || lo !== l0) stable = 1'b0;
      end else begin
        break;
      end
    end
    chk({name, "_busy_cycles"}, n, exp_n);
    chk({name, "_hilo_stable"}, {31'd0, stable}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: any commit (busy falling, or HI/LO changing while idle) pops the scoreboard.
  logic        pb;
  logic [31:0] ph, pl;
  exp_t        me;
  initial begin
    pb = 1'b0;
    ph = '0;
    pl = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if ((pb && !busy) || (!pb && !busy && (hi !== ph || lo !== pl))) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_update: hi=%h lo=%h, expected no update", hi, lo);
          end else begin
            me = exp_q.pop_front();
            chk("mon_hi", hi, me.h);
            chk("mon_lo", lo, me.l);
          end
        end
      end
      pb = busy;
      ph = hi;
      pl = lo;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    rs_data = '0;
    rt_data = '0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    push(32'hFFFFFFFF, 32'hFFFFFFFA);
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    run_busy("mult_neg", 5);

    // Back-to-back: launched at the first edge with busy low.
    push(32'hFFFFFFFE, 32'h00000001);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_busy("multu_max", 5);

    push(32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    run_busy("div_neg", 10);

    push(32'h00000011, 32'hFFFFFFFD);
    issue(3'd4, 32'h11, 32'h0);
    push(32'h00000011, 32'h00000022);
    issue(3'd5, 32'h22, 32'h0);
    @(negedge clk);
    chk("mt_no_busy", {31'd0, busy}, 32'd0);

    push(32'h00000011, 32'h00000022);
    issue(3'd3, 32'd7, 32'd0);
    run_busy("divu_zero", 10);

    push(32'h00000000, 32'h80000000);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_busy("div_ovf", 10);

    push(32'h00000001, 32'hFFFFFFFD);
    issue(3'd2, 32'd7, 32'hFFFFFFFE);
    run_busy("div_negdiv", 10);

    // MTHI while busy is ignored; operand changes mid-run have no effect.
    push(32'h00000002, 32'h0000000E);
    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    issue(3'd4, 32'hDEADBEEF, 32'd1);
    issue(3'd3, 32'd9, 32'd3);
    wait_idle("mthi_busy");
    push(32'hDEADBEEF, 32'h0000000E);
    issue(3'd4, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    chk("mthi_after_busy", {31'd0, busy}, 32'd0);

    // Async reset in the third RUN cycle aborts the pending result.
    issue(3'd0, 32'd5, 32'd6);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_late_lo", lo, 32'd0);
    chk("abort_late_busy", {31'd0, busy}, 32'd0);

    push(32'h00000000, 32'hFFFFFFFF);
    issue(3'd5, 32'hFFFFFFFF, 32'd0);
    @(negedge clk);
`ifdef MDU_MADD_EN
    push(32'h00000001, 32'h00000000);
    issue(3'd7, 32'd1, 32'd1);
    run_busy("maddu", 5);
    push(32'h00000000, 32'hFFFFFFFF);
    issue(3'd6, 32'hFFFFFFFF, 32'd1);
    run_busy("madd", 5);
`else
    issue(3'd7, 32'd1, 32'd1);
    @(negedge clk);
    chk("maddu_off_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("madd_off_hi", hi, 32'd0);
    chk("madd_off_lo", lo, 32'hFFFFFFFF);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. It sits beside the datapath ALU, consumes the rs/rt register-file read values and a decoded operation from control, and models multi-cycle latency with a `busy` flag. Control uses `busy` to stall the IFU, and the datapath reads `hi`/`lo` for mfhi/mflo.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy duration for mult/multu (and madd/maddu); legal range 1..15.
- DIV_CYCLES, default 10: busy duration for div/divu; legal range 1..15.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  launch or execute the operation on `op` this cycle.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
- rs_data  in  32  operand A (dividend, or multiplicand, or mthi/mtlo source).
- rt_data  in  32  operand B (divisor or multiplier).
- busy  out  1  a mult/div operation is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- Reset values: busy=0, hi=0, lo=0, counter=0, pending result=0.
- State machine: IDLE (busy=0) and RUN (busy=1, 4-bit down-counter active).
- IDLE, start=1, op MULT/MULTU/DIV/DIVU/MADD/MADDU:
  - compute the result from the current operands;
  - latch it into pending {phi, plo};
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, start=1, op MTHI/MTLO: write rs_data to hi or lo at that edge. Single cycle; busy is not raised.
- RUN: the counter decrements each edge. On the edge where it reaches 0:
  - hi/lo take the pending values;
  - busy falls;
  - the unit returns to IDLE.
- start while busy=1: ignored entirely, including MTHI/MTLO. Control must stall instead.
- MULT: {hi,lo} = signed 32x32 to 64-bit product.
- MULTU: {hi,lo} = unsigned 32x32 to 64-bit product.
- DIV (signed): lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
- DIVU (unsigned): lo = unsigned quotient; hi = unsigned remainder.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divisor 0 (DIV/DIVU): the unit still runs DIV_CYCLES, and pending is set to the current hi/lo, so HI/LO are unchanged.
- Operands are sampled only at launch. Later changes on rs_data/rt_data have no effect.
- Reset asserted in RUN: the operation is aborted, pending is discarded, and all outputs return to reset values asynchronously.

## Timing
- Launch at edge E0 gives busy=1 from E0 until E_N. N = MULT_CYCLES or DIV_CYCLES, so busy is high for exactly N cycles.
- hi/lo change only at E_N (mult/div) or E0 (mthi/mtlo). They are stable and readable in every other cycle, including during RUN, where they show the old values.
- A back-to-back launch is accepted at the first edge with busy=0, i.e. the edge after E_N at the earliest.
- Outputs are registered. There is no combinational path from inputs to busy, hi or lo.

## Configuration
- MDU_MADD_EN defined: op 6 MADD performs {hi,lo} += signed rs*rt, and op 7 MADDU performs {hi,lo} += unsigned rs*rt. Both use 64-bit modular wrap, latency MULT_CYCLES, and the {hi,lo} value sampled at launch.
- MDU_MADD_EN undefined: ops 6 and 7 are no-ops. start is ignored, busy stays 0 and hi/lo are unchanged.

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3. Expect busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Expect hi/lo=0 throughout RUN.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF. Expect hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV rs=-7 (0xFFFFFFF9), rt=2. Expect after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU rs=7, rt=0 with hi/lo preset via MTHI 0x11/MTLO 0x22. Expect busy for 10 cycles and hi=0x11, lo=0x22 unchanged.
- MTHI 0xDEADBEEF, issued while a DIV is busy, is ignored. Reissued after busy falls, hi=0xDEADBEEF at the next edge with busy never asserted.
- Launch MULT 5*6, assert reset in cycle 3 of RUN. Expect busy, hi and lo all 0 immediately, and no later update to lo=30.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU 1*1 gives hi=1, lo=0. Without MDU_MADD_EN: the same stimulus leaves busy=0 and hi=0, lo=0xFFFFFFFF.
